// File: rtl/divide_sequencer.sv
// Request FIFO plus IDLE/ISSUE/WAIT/DONE sequencer that drives an external iterative Divider.
// Define DIVSEQ_ZERO_BYPASS_EN to answer divide-by-zero requests locally without using the Divider.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the FIFO head into the operand registers
// ISSUE | one-cycle start pulse to the Divider
// WAIT  | operands held stable until the Divider reports finished
// DONE  | result held on o_quotient/o_remainder until the consumer accepts it
module divide_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_div_start,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  input  logic         i_div_finished,
  input  logic [N-1:0] i_div_quotient,
  input  logic [N-1:0] i_div_remainder,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero,
  output logic         o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  mem_dividend [DEPTH];
  logic [N-1:0]  mem_divisor  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pend_q;
  logic          push;
  logic          pop;
  logic [N-1:0]  op_dividend;
  logic [N-1:0]  op_divisor;

  assign o_ready        = (count != CNT_FULL);
  assign push           = i_valid & o_ready;
  // pend_q lags count by one edge; IDLE is never entered on the edge of a pop,
  // so it can only under-report and never pops an empty FIFO.
  assign pop            = (state == IDLE) & pend_q;
  assign o_div_start    = (state == ISSUE);
  assign o_valid        = (state == DONE);
  assign o_busy         = (state != IDLE);
  assign o_div_dividend = op_dividend;
  assign o_div_divisor  = op_divisor;

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_dividend[wr_ptr] <= i_dividend;
      mem_divisor[wr_ptr]  <= i_divisor;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      pend_q <= (count != '0);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      op_dividend   <= '0;
      op_divisor    <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_dividend <= mem_dividend[rd_ptr];
            op_divisor  <= mem_divisor[rd_ptr];
`ifdef DIVSEQ_ZERO_BYPASS_EN
            if (mem_divisor[rd_ptr] == '0) begin
              o_quotient    <= '1;
              o_remainder   <= mem_dividend[rd_ptr];
              o_div_by_zero <= 1'b1;
              state         <= DONE;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (i_div_finished) begin
            o_quotient    <= i_div_quotient;
            o_remainder   <= i_div_remainder;
            o_div_by_zero <= (op_divisor == '0);
            state         <= DONE;
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_sequencer.sv
// Directed bench for divide_sequencer with a behavioural Divider (start sampled, finished N-1 edges later).
// Expected latencies follow the DIVSEQ_ZERO_BYPASS_EN setting of the build.
module tb_divide_sequencer;
  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int DIV_LAT = N - 1;
`ifdef DIVSEQ_ZERO_BYPASS_EN
  localparam int ZLAT    = 2;
  localparam int ZSTARTS = 0;
`else
  localparam int ZLAT    = N + 2;
  localparam int ZSTARTS = 1;
`endif

  logic         clk_sys = 1'b0;
  logic         rst_b;
  logic         i_valid, o_ready, o_div_start, i_div_finished;
  logic [N-1:0] i_dividend, i_divisor, o_div_dividend, o_div_divisor;
  logic [N-1:0] i_div_quotient, i_div_remainder, o_quotient, o_remainder;
  logic         o_valid, i_ready, o_div_by_zero, o_busy;

  logic [N-1:0] dq, dr;
  int           div_cnt;
  logic         fin_force;
  int           n_start;
  int           n_checks = 0;
  int           n_errors = 0;

  divide_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clock(clk_sys), .i_reset_n(rst_b),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_div_start(o_div_start), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .i_div_finished(i_div_finished), .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder),
    .o_div_by_zero(o_div_by_zero), .o_busy(o_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // behavioural Divider, reset together with the sequencer
  always @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= 0;
      dq      <= '0;
      dr      <= '0;
    end else if (o_div_start) begin
      div_cnt <= DIV_LAT;
      dq      <= (o_div_divisor == 0) ? '1 : o_div_dividend / o_div_divisor;
      dr      <= (o_div_divisor == 0) ? o_div_dividend : o_div_dividend % o_div_divisor;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end
  end

  assign i_div_finished  = (div_cnt == 1) | fin_force;
  assign i_div_quotient  = fin_force ? 8'hAA : dq;
  assign i_div_remainder = fin_force ? 8'h55 : dr;

  always @(posedge clk_sys) if (o_div_start) n_start++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [N-1:0] dd, input logic [N-1:0] dv);
    i_valid    = 1'b1;
    i_dividend = dd;
    i_divisor  = dv;
    for (int k = 0; k < 200; k++) begin
      if (o_ready) break;
      tick();
    end
    check("send_ready", o_ready, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic take(input string tag, input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    for (int k = 0; k < 100 && !o_valid; k++) tick();
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_q"}, o_quotient, eq);
    check({tag, "_r"}, o_remainder, er);
    check({tag, "_dbz"}, o_div_by_zero, ez);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, bad_ready, bad_hold;
    rst_b = 1'b0; i_valid = 1'b0; i_ready = 1'b0; fin_force = 1'b0;
    i_dividend = '0; i_divisor = '0; n_start = 0;
    #3;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_div_start, 0);
    check("rst_q", o_quotient, 0);
    check("rst_dbz", o_div_by_zero, 0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();

    // 100/7 into an idle unit with the consumer always ready
    i_ready = 1'b1;
    s0 = n_start;
    send(8'd100, 8'd7);
    wait_valid(lat);
    check("basic_lat", lat, 10);
    check("basic_q", o_quotient, 14);
    check("basic_r", o_remainder, 2);
    check("basic_dbz", o_div_by_zero, 0);
    check("basic_starts", n_start - s0, 1);
    tick();
    check("basic_exit_valid", o_valid, 0);
    check("basic_exit_busy", o_busy, 0);
    i_ready = 1'b0;

    // A held in DONE while four more fill the FIFO and a fifth waits
    send(8'd120, 8'd11);
    wait_valid(lat);
    check("a_lat", lat, 10);
    s0 = n_start;
    send(8'd50, 8'd5);
    send(8'd255, 8'd16);
    send(8'd7, 8'd9);
    send(8'd33, 8'd4);
    check("full_ready", o_ready, 0);
    i_valid = 1'b1; i_dividend = 8'd90; i_divisor = 8'd8;
    bad_ready = 0; bad_hold = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_ready) bad_ready++;
      if (!o_valid || o_quotient != 8'd10 || o_remainder != 8'd10 || o_div_by_zero) bad_hold++;
    end
    check("stall_ready_low", bad_ready, 0);
    check("stall_hold", bad_hold, 0);
    check("stall_no_start", n_start - s0, 0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("fifth_still_held", o_ready, 0);
    for (int k = 0; k < 20 && !o_ready; k++) tick();
    check("fifth_ready", o_ready, 1);
    tick();
    i_valid = 1'b0;
    take("b", 8'd10, 8'd0, 1'b0);
    take("c", 8'd15, 8'd15, 1'b0);
    take("d", 8'd0, 8'd7, 1'b0);
    take("e", 8'd8, 8'd1, 1'b0);
    take("f", 8'd11, 8'd2, 1'b0);
    check("drain_busy", o_busy, 0);

    // divide by zero
    s0 = n_start;
    send(8'd200, 8'd0);
    wait_valid(lat);
    check("zero_lat", lat, ZLAT);
    check("zero_q", o_quotient, 255);
    check("zero_r", o_remainder, 200);
    check("zero_dbz", o_div_by_zero, 1);
    check("zero_starts", n_start - s0, ZSTARTS);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // reset while waiting on the Divider, with a second request queued
    s0 = n_start;
    send(8'd60, 8'd7);
    for (int k = 0; k < 50 && n_start == s0; k++) tick();
    send(8'd9, 8'd9);
    check("wait_busy", o_busy, 1);
    check("wait_op_dd", o_div_dividend, 60);
    check("wait_op_dv", o_div_divisor, 7);
    #2 rst_b = 1'b0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_q", o_quotient, 0);
    check("midrst_r", o_remainder, 0);
    check("midrst_dbz", o_div_by_zero, 0);
    tick();
    rst_b = 1'b1;
    bad_hold = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (o_busy || o_valid) bad_hold++;
    end
    check("flushed_idle", bad_hold, 0);
    send(8'd9, 8'd3);
    wait_valid(lat);
    check("post_rst_lat", lat, 10);

    // stray finished pulses in DONE and in IDLE
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    tick();
    check("done_pulse_valid", o_valid, 1);
    take("post_rst", 8'd3, 8'd0, 1'b0);
    tick();
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    tick();
    check("idle_pulse_busy", o_busy, 0);
    check("idle_pulse_valid", o_valid, 0);
    check("idle_pulse_q", o_quotient, 3);
    check("idle_pulse_r", o_remainder, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
